// File: rtl/spmp_walk_ctrl.sv
// Sequential SPMP checker: walks the entry table one entry per cycle, first match wins.
// Optional macro SPMP_WALK_EARLY_EXIT_EN stops the walk at the first match.
module spmp_walk_ctrl #(
    parameter int unsigned NrEntries = 64,
    parameter int unsigned PlenWidth = 56,
    parameter int unsigned IdxWidth  = (NrEntries > 1) ? $clog2(NrEntries) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [PlenWidth-1:0] req_addr_i,
    input  logic [1:0]           req_acc_i,
    input  logic                 no_match_allow_i,
    output logic                 rd_en_o,
    output logic [IdxWidth-1:0]  rd_idx_o,
    input  logic [7:0]           rd_cfg_i,
    input  logic [PlenWidth-3:0] rd_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_allow_o,
    output logic                 rsp_match_o,
    output logic [IdxWidth-1:0]  rsp_idx_o
);

    localparam int unsigned EaWidth = PlenWidth - 2;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NrEntries - 1);

    typedef enum logic [1:0] {IDLE, WALK, RESP} state_e;

    state_e                state_q;
    logic                  ready_q;
    logic                  rd_en_q;
    logic [IdxWidth-1:0]   rd_idx_q;
    logic                  vld_p1;
    logic [IdxWidth-1:0]   idx_p1;
    logic [EaWidth-1:0]    wa_q;
    logic [EaWidth-1:0]    prev_q;
    logic [1:0]            acc_q;
    logic                  nm_allow_q;
    logic                  rsp_valid_q;
    logic                  rsp_allow_q;
    logic                  rsp_match_q;
    logic [IdxWidth-1:0]   rsp_idx_q;
`ifndef SPMP_WALK_EARLY_EXIT_EN
    logic                  found_q;
    logic                  found_allow_q;
    logic [IdxWidth-1:0]   found_idx_q;
`endif

    logic hit_p1;
    logic perm_p1;
    logic unused_bits;

    // Bits [t:0] set, where t is the count of trailing ones of ea.
    function automatic logic [EaWidth-1:0] napot_mask(input logic [EaWidth-1:0] ea);
        logic [EaWidth-1:0] ea_inc;
        ea_inc = ea + EaWidth'(1);
        return ea ^ ea_inc;
    endfunction

    function automatic logic entry_hit(input logic [1:0]         a,
                                       input logic [EaWidth-1:0] ea,
                                       input logic [EaWidth-1:0] prev,
                                       input logic [EaWidth-1:0] wa);
        logic [EaWidth-1:0] m;
        m = napot_mask(ea);
        case (a)
            2'd1:    return (prev <= wa) && (wa < ea);
            2'd2:    return wa == ea;
            2'd3:    return (wa & ~m) == (ea & ~m);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic perm_bit(input logic [2:0] rwx, input logic [1:0] acc);
        case (acc)
            2'd0:    return rwx[0];
            2'd1:    return rwx[1];
            2'd2:    return rwx[2];
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        hit_p1  = entry_hit(rd_cfg_i[4:3], rd_addr_i, prev_q, wa_q);
        perm_p1 = perm_bit(rd_cfg_i[2:0], acc_q);
    end

    assign unused_bits = ^{rd_cfg_i[7:5], req_addr_i[1:0]};

    // A flush kills the read strobe and any pending response in the same cycle.
    assign rd_en_o     = rd_en_q && !flush_i;
    assign rd_idx_o    = rd_idx_q;
    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q && !flush_i;
    assign rsp_allow_o = rsp_allow_q;
    assign rsp_match_o = rsp_match_q;
    assign rsp_idx_o   = rsp_idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rd_en_q     <= 1'b0;
            rd_idx_q    <= '0;
            vld_p1      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_allow_q <= 1'b0;
            rsp_match_q <= 1'b0;
            rsp_idx_q   <= '0;
`ifndef SPMP_WALK_EARLY_EXIT_EN
            found_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && !flush_i) begin
                        wa_q       <= req_addr_i[PlenWidth-1:2];
                        acc_q      <= req_acc_i;
                        nm_allow_q <= no_match_allow_i;
                        prev_q     <= '0;
                        rd_idx_q   <= '0;
                        rd_en_q    <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= WALK;
`ifndef SPMP_WALK_EARLY_EXIT_EN
                        found_q    <= 1'b0;
`endif
                    end
                end
                WALK: begin
                    if (flush_i) begin
                        state_q  <= IDLE;
                        ready_q  <= 1'b1;
                        rd_en_q  <= 1'b0;
                        rd_idx_q <= '0;
                        vld_p1   <= 1'b0;
                    end else begin
                        // stage p0 -> p1: issued index travels with its data-valid flag
                        vld_p1 <= rd_en_q;
                        idx_p1 <= rd_idx_q;
                        if (rd_en_q) begin
                            if (rd_idx_q == LastIdx) rd_en_q <= 1'b0;
                            else                     rd_idx_q <= rd_idx_q + 1'b1;
                        end
                        // stage p1: compare entry data against the latched request
                        if (vld_p1) begin
                            prev_q <= rd_addr_i;
`ifdef SPMP_WALK_EARLY_EXIT_EN
                            if (hit_p1 || idx_p1 == LastIdx) begin
                                state_q     <= RESP;
                                rd_en_q     <= 1'b0;
                                rd_idx_q    <= '0;
                                vld_p1      <= 1'b0;
                                rsp_valid_q <= 1'b1;
                                rsp_allow_q <= hit_p1 ? perm_p1 : nm_allow_q;
                                rsp_match_q <= hit_p1;
                                rsp_idx_q   <= hit_p1 ? idx_p1 : '0;
                            end
`else
                            if (hit_p1 && !found_q) begin
                                found_q       <= 1'b1;
                                found_allow_q <= perm_p1;
                                found_idx_q   <= idx_p1;
                            end
                            if (idx_p1 == LastIdx) begin
                                state_q     <= RESP;
                                rd_en_q     <= 1'b0;
                                rd_idx_q    <= '0;
                                vld_p1      <= 1'b0;
                                rsp_valid_q <= 1'b1;
                                if (found_q) begin
                                    rsp_allow_q <= found_allow_q;
                                    rsp_match_q <= 1'b1;
                                    rsp_idx_q   <= found_idx_q;
                                end else begin
                                    rsp_allow_q <= hit_p1 ? perm_p1 : nm_allow_q;
                                    rsp_match_q <= hit_p1;
                                    rsp_idx_q   <= hit_p1 ? idx_p1 : '0;
                                end
                            end
`endif
                        end
                    end
                end
                RESP: begin
                    if (flush_i || rsp_ready_i) begin
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spmp_walk_ctrl.sv
// Directed self-checking bench for spmp_walk_ctrl with a 1-cycle-latency entry table model.
module tb_spmp_walk_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [55:0] req_addr;
    logic [1:0]  req_acc;
    logic        no_match_allow;
    logic        rd_en;
    logic [5:0]  rd_idx;
    logic [7:0]  rd_cfg;
    logic [53:0] rd_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_allow;
    logic        rsp_match;
    logic [5:0]  rsp_idx;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tcfg  [64];
    logic [53:0] taddr [64];

    spmp_walk_ctrl #(.NrEntries(64), .PlenWidth(56)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_acc_i(req_acc), .no_match_allow_i(no_match_allow),
        .rd_en_o(rd_en), .rd_idx_o(rd_idx), .rd_cfg_i(rd_cfg), .rd_addr_i(rd_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_allow_o(rsp_allow), .rsp_match_o(rsp_match), .rsp_idx_o(rsp_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_cfg  <= tcfg[rd_idx];
            rd_addr <= taddr[rd_idx];
        end
    end

    function automatic int hit_lat(input int k);
`ifdef SPMP_WALK_EARLY_EXIT_EN
        return 3 + k;
`else
        return 66;
`endif
    endfunction

    task automatic clear_table();
        for (int i = 0; i < 64; i++) begin
            tcfg[i]  = 8'h00;
            taddr[i] = '0;
        end
    endtask

    // Drives one request (called #1 after an edge with req_ready high) and completes the handshake.
    task automatic do_req(input logic [55:0] addr, input logic [1:0] acc, input logic nma,
                          output logic allow, output logic match, output logic [5:0] idx,
                          output int lat);
        req_addr       = addr;
        req_acc        = acc;
        no_match_allow = nma;
        req_valid      = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        allow = rsp_allow;
        match = rsp_match;
        idx   = rsp_idx;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rd_en, rd_idx, rsp_valid, rsp_allow, rsp_match, rsp_idx} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rd_en=%b rd_idx=%0d rsp_valid=%b allow=%b match=%b idx=%0d, required 1 0 0 0 0 0 0",
                     req_ready, rd_en, rd_idx, rsp_valid, rsp_allow, rsp_match, rsp_idx);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_napot();
        logic a, m; logic [5:0] ix; int lat;
        clear_table();
        tcfg[3]  = 8'h19;
        taddr[3] = 54'h2000_03FF;
        tcfg[5]  = 8'h1A;
        taddr[5] = {54{1'b1}};
        do_req(56'h8000_0010, 2'd0, 1'b0, a, m, ix, lat);
        checks++;
        if ({a, m, ix} !== {1'b1, 1'b1, 6'd3}) begin
            errors++;
            $display("FAIL napot_read: allow=%b match=%b idx=%0d, required 1 1 3", a, m, ix);
        end
        checks++;
        if (lat != hit_lat(3)) begin
            errors++;
            $display("FAIL napot_read_latency: got %0d, required %0d", lat, hit_lat(3));
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL napot_ready_after: got %b, required 1", req_ready);
        end
        do_req(56'h8000_0010, 2'd1, 1'b1, a, m, ix, lat);
        checks++;
        if ({a, m, ix} !== {1'b0, 1'b1, 6'd3}) begin
            errors++;
            $display("FAIL napot_write_priority: allow=%b match=%b idx=%0d, required 0 1 3", a, m, ix);
        end
        do_req(56'h8000_0010, 2'd3, 1'b1, a, m, ix, lat);
        checks++;
        if ({a, m, ix} !== {1'b0, 1'b1, 6'd3}) begin
            errors++;
            $display("FAIL napot_acc3: allow=%b match=%b idx=%0d, required 0 1 3", a, m, ix);
        end
        do_req(56'h0000_0000, 2'd1, 1'b0, a, m, ix, lat);
        checks++;
        if ({a, m, ix} !== {1'b1, 1'b1, 6'd5}) begin
            errors++;
            $display("FAIL napot_all_ones: allow=%b match=%b idx=%0d, required 1 1 5", a, m, ix);
        end
        checks++;
        if (lat != hit_lat(5)) begin
            errors++;
            $display("FAIL napot_all_ones_latency: got %0d, required %0d", lat, hit_lat(5));
        end
    endtask

    task automatic test_tor();
        logic a, m; logic [5:0] ix; int lat;
        clear_table();
        tcfg[0]  = 8'h10;
        taddr[0] = 54'h100;
        tcfg[1]  = 8'h0C;
        taddr[1] = 54'h200;
        do_req(56'h600, 2'd2, 1'b0, a, m, ix, lat);
        checks++;
        if ({a, m, ix, lat} !== {1'b1, 1'b1, 6'd1, hit_lat(1)}) begin
            errors++;
            $display("FAIL tor_hit: allow=%b match=%b idx=%0d lat=%0d, required 1 1 1 %0d", a, m, ix, lat, hit_lat(1));
        end
        do_req(56'h800, 2'd2, 1'b1, a, m, ix, lat);
        checks++;
        if ({a, m, ix, lat} !== {1'b1, 1'b0, 6'd0, 66}) begin
            errors++;
            $display("FAIL tor_upper_bound_nma1: allow=%b match=%b idx=%0d lat=%0d, required 1 0 0 66", a, m, ix, lat);
        end
        do_req(56'h800, 2'd2, 1'b0, a, m, ix, lat);
        checks++;
        if ({a, m, ix} !== {1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL tor_upper_bound_nma0: allow=%b match=%b idx=%0d, required 0 0 0", a, m, ix);
        end
        do_req(56'h400, 2'd2, 1'b0, a, m, ix, lat);
        checks++;
        if ({a, m, ix} !== {1'b0, 1'b1, 6'd0}) begin
            errors++;
            $display("FAIL na4_hit_first: allow=%b match=%b idx=%0d, required 0 1 0", a, m, ix);
        end
    endtask

    task automatic test_all_off();
        logic a, m; logic [5:0] ix; int lat;
        clear_table();
        do_req(56'h1234_5678, 2'd0, 1'b0, a, m, ix, lat);
        checks++;
        if ({a, m, ix, lat} !== {1'b0, 1'b0, 6'd0, 66}) begin
            errors++;
            $display("FAIL all_off: allow=%b match=%b idx=%0d lat=%0d, required 0 0 0 66", a, m, ix, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic a, m; logic [5:0] ix; int lat; int stable;
        clear_table();
        tcfg[3]  = 8'h19;
        taddr[3] = 54'h2000_03FF;
        req_addr = 56'h8000_0010; req_acc = 2'd0; no_match_allow = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if ({rd_en, rd_idx, req_ready} !== {1'b1, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL walk_start: rd_en=%b rd_idx=%0d ready=%b, required 1 0 0", rd_en, rd_idx, req_ready);
        end
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            if ({rsp_valid, rsp_allow, rsp_match, rsp_idx, req_ready} !== {1'b1, 1'b1, 1'b1, 6'd3, 1'b0}) stable = 0;
            @(posedge clk); #1;
        end
        checks++;
        if (stable != 1) begin
            errors++;
            $display("FAIL hold_stable: got %0d, required 1", stable);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL after_handshake: ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
        end
        do_req(56'h8000_0014, 2'd0, 1'b0, a, m, ix, lat);
        checks++;
        if ({a, m, ix, lat} !== {1'b1, 1'b1, 6'd3, hit_lat(3)}) begin
            errors++;
            $display("FAIL back_to_back: allow=%b match=%b idx=%0d lat=%0d, required 1 1 3 %0d", a, m, ix, lat, hit_lat(3));
        end
    endtask

    task automatic test_flush();
        int seen;
        clear_table();
        req_addr = 56'h40; req_acc = 2'd0; no_match_allow = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({rd_en, rd_idx} !== {1'b1, 6'd9}) begin
            errors++;
            $display("FAIL flush_pre: rd_en=%b rd_idx=%0d, required 1 9", rd_en, rd_idx);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (rd_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_rd_en: got %b, required 0", rd_en);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, rd_en} !== 3'b100) begin
            errors++;
            $display("FAIL flush_idle: ready=%b rsp_valid=%b rd_en=%b, required 1 0 0", req_ready, rsp_valid, rd_en);
        end
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (rsp_valid || rd_en) seen = 1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_response: got %0d, required 0", seen);
        end
    endtask

    task automatic test_reset_mid_walk();
        logic a, m; logic [5:0] ix; int lat;
        clear_table();
        tcfg[3]  = 8'h19;
        taddr[3] = 54'h2000_03FF;
        do_req(56'h8000_0010, 2'd0, 1'b0, a, m, ix, lat);
        req_addr = 56'h8000_0010; req_acc = 2'd0; no_match_allow = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, rd_en, rd_idx, rsp_valid, rsp_allow, rsp_match, rsp_idx} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL reset_mid_walk: ready=%b rd_en=%b rd_idx=%0d rsp_valid=%b allow=%b match=%b idx=%0d, required 1 0 0 0 0 0 0",
                     req_ready, rd_en, rd_idx, rsp_valid, rsp_allow, rsp_match, rsp_idx);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        clear_table();
        do_req(56'h8000_0010, 2'd0, 1'b1, a, m, ix, lat);
        checks++;
        if ({a, m, ix, lat} !== {1'b1, 1'b0, 6'd0, 66}) begin
            errors++;
            $display("FAIL after_reset_walk: allow=%b match=%b idx=%0d lat=%0d, required 1 0 0 66", a, m, ix, lat);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0;
        req_acc = 2'd0; no_match_allow = 1'b0; rsp_ready = 1'b0;
        rd_cfg = '0; rd_addr = '0;
        clear_table();
        test_reset();
        test_napot();
        test_tor();
        test_all_off();
        test_back_to_back();
        test_flush();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spmp_walk_ctrl.md
# spmp_walk_ctrl

Sequential SPMP checker that decides one physical access at a time against the SPMP entry table. It walks the entries one per cycle through a 1-cycle-latency read port on the CSR-side entry storage. Priority is first-match-wins, by lowest index. It sits between the LSU/fetch permission-request path and the SPMP entry RAM, so the 64-entry table never needs a flat fan-out comparator.

## Interface
Parameters:
- NrEntries, 64, number of SPMP entries walked (1..64)
- PlenWidth, 56, physical address width; entry addresses hold bits [PlenWidth-1:2]
- IdxWidth, $clog2(NrEntries) (min 1), entry index width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  abort the current walk; no response is produced
- req_valid_i / req_ready_o  in/out  1  request handshake
- req_addr_i  in  PlenWidth  physical byte address
- req_acc_i  in  2  access type: 0 read, 1 write, 2 execute (3 is treated as denied)
- no_match_allow_i  in  1  verdict when no entry matches; sampled with the request
- rd_en_o  out  1  entry read strobe
- rd_idx_o  out  IdxWidth  entry index to read
- rd_cfg_i  in  8  cfg of the entry read in the previous cycle: [0]R [1]W [2]X [4:3]A
- rd_addr_i  in  PlenWidth-2  address of the entry read in the previous cycle
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake
- rsp_allow_o  out  1  access permitted
- rsp_match_o  out  1  an entry matched
- rsp_idx_o  out  IdxWidth  index of the matching entry (0 if none)

## Operation
- FSM states: IDLE, WALK, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch the request: word address = addr[PlenWidth-1:2], access type, no-match verdict.
  - Set issue index=0 and prev_addr=0, then go to WALK.
- WALK:
  - rd_en_o=1 and rd_idx_o=issue index; the index increments each cycle up to NrEntries-1, then rd_en_o drops.
  - A valid flag pipelined one cycle behind rd_en_o marks when rd_cfg_i/rd_addr_i are meaningful for entry k.
- Match rules per entry k (A field), comparing word address `wa` with entry address `ea`:
  - A=0 OFF: never matches.
  - A=1 TOR: prev_addr <= wa < ea, unsigned. prev_addr is the ea of entry k-1 (0 for k=0). prev_addr is updated on every valid data cycle, whatever the A field.
  - A=2 NA4: wa == ea.
  - A=3 NAPOT: let t = count of trailing ones of ea. Compare wa with ea with bits [t:0] masked. All-ones ea matches everything.
- First match:
  - allow = the cfg bit selected by the access type (R/W/X).
  - rsp_match=1, rsp_idx=k.
- No match after entry NrEntries-1: allow = latched no_match_allow, match=0, idx=0.
- RESP:
  - Response outputs are registered and held stable until rsp_ready_i; then go to IDLE.
  - req_ready_o=0 in WALK and RESP.
- flush_i:
  - In WALK or RESP: go to IDLE next cycle; rd_en_o deasserts that same cycle; no response.
  - In IDLE: no effect. flush_i has priority over req_valid_i.
- Reset: state=IDLE, req_ready_o=1, rd_en_o=0, rd_idx_o=0, rsp_valid_o=0, rsp_allow_o=0, rsp_match_o=0, rsp_idx_o=0. Reset mid-walk discards the request.

## Timing
- Acceptance edge = cycle A.
- Entry k is read in cycle A+1+k; its data arrives in cycle A+2+k and is compared combinationally in that cycle.
- Early-exit latency: match at entry k gives rsp_valid_o in cycle A+3+k.
- Full-walk latency: rsp_valid_o in cycle A+NrEntries+2.
- The read issued in the same cycle as the deciding compare is speculative and its data is ignored.
- Back-to-back requests: the earliest next acceptance is the cycle after the rsp handshake, because req_ready_o rises on return to IDLE.

## Configuration
- Macro: SPMP_WALK_EARLY_EXIT_EN.
- Defined: the walk stops at the first match; latency varies with the matching index.
- Undefined: all NrEntries entries are always read. The first match is still recorded and later matches are ignored. The response is issued only after the last entry, so latency is constant at NrEntries+2 (timing-channel-free).
- The verdict is identical in both builds.

## Test plan
- NrEntries=64, entry 3 NAPOT ea=0x2000_03FF (t=10) cfg R=1 W=0; read of byte address 0x8000_0010 -> allow=1, match=1, idx=3, rsp_valid at A+6 (early exit) or A+66 (full walk).
- Same table, write to the same address -> allow=0, match=1, idx=3.
- Entry 0 NA4 ea=0x100, entry 1 TOR ea=0x200 cfg X=1; execute at byte address 0x600 -> match idx=1, allow=1. Same request at 0x800 -> no match, allow = no_match_allow_i.
- All entries OFF, no_match_allow_i=0 -> match=0, allow=0, idx=0, rsp_valid at A+66.
- Hold rsp_ready_i low for 5 cycles -> rsp_* stable and req_ready_o=0 throughout; the handshake is followed by acceptance of the next request the cycle after.
- flush_i asserted in cycle A+10 of a walk -> rd_en_o=0 in that cycle, no rsp_valid_o, req_ready_o=1 in A+11. Assert rst_i mid-walk -> all outputs return to their reset values the next cycle.
